// File: rtl/spi_word_target.sv
// SPI mode-0 word target: 8-bit command, 16-bit address, then 16-bit data words
// read from or written to a small register array with an auto-incrementing pointer.
module spi_word_target #(
    parameter int unsigned ADDR_BITS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic spi_cs,
    input  logic spi_clk,
    input  logic spi_mosi,
    output logic spi_miso,
    output logic xfer_done
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] PTR_ONE = 1;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, WRITE, IGNORE} state_t;

    state_t                 state;
    logic                   sck_q;
    logic [6:0]             cmd_sr;
    logic                   is_read;
    logic [ADDR_BITS-1:0]   addr_sr;
    logic [ADDR_BITS-1:0]   ptr;
    logic [14:0]            shreg;
    logic [3:0]             bitcnt;
    logic [3:0]             rdbit;
    logic [15:0]            mem [DEPTH];

    logic                   rise;
    logic                   fall;
    logic [7:0]             cmd_next;
    logic [ADDR_BITS-1:0]   addr_next;

    always_comb begin
        rise      = spi_clk && !sck_q && !spi_cs;
        fall      = !spi_clk && sck_q && !spi_cs;
        cmd_next  = {cmd_sr, spi_mosi};
        // Only the low address bits are kept; upper bits shift straight out.
        addr_next = {addr_sr[ADDR_BITS-2:0], spi_mosi};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sck_q     <= 1'b0;
            cmd_sr    <= '0;
            is_read   <= 1'b0;
            addr_sr   <= '0;
            ptr       <= '0;
            shreg     <= '0;
            bitcnt    <= '0;
            rdbit     <= '0;
            spi_miso  <= 1'b0;
            xfer_done <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i[ADDR_BITS-1:0]] <= '0;
            end
        end else begin
            sck_q     <= spi_clk;
            xfer_done <= 1'b0;
            if (spi_cs) begin
                state     <= IDLE;
                spi_miso  <= 1'b0;
                xfer_done <= (state == READ) || (state == WRITE);
            end else begin
                case (state)
                    IDLE: begin
                        // A rise in the select cycle is already command bit 7.
                        state    <= CMD;
                        spi_miso <= 1'b0;
                        rdbit    <= '0;
                        if (rise) begin
                            cmd_sr <= cmd_next[6:0];
                            bitcnt <= 4'd1;
                        end else begin
                            bitcnt <= '0;
                        end
                    end
                    CMD: begin
                        spi_miso <= 1'b0;
                        if (rise) begin
                            cmd_sr <= cmd_next[6:0];
                            bitcnt <= bitcnt + 4'd1;
                            if (bitcnt == 4'd7) begin
                                bitcnt  <= '0;
                                is_read <= (cmd_next == 8'h03);
                                if (cmd_next == 8'h03 || cmd_next == 8'h02) begin
                                    state <= ADDR;
                                end else begin
                                    state <= IGNORE;
                                end
                            end
                        end
                    end
                    ADDR: begin
                        spi_miso <= 1'b0;
                        if (rise) begin
                            addr_sr <= addr_next;
                            bitcnt  <= bitcnt + 4'd1;
                            if (bitcnt == 4'd15) begin
                                bitcnt <= '0;
                                ptr    <= addr_next;
                                state  <= is_read ? READ : WRITE;
                            end
                        end
                    end
                    READ: begin
                        if (fall) begin
                            spi_miso <= mem[ptr][4'd15 - rdbit];
                            rdbit    <= rdbit + 4'd1;
                            if (rdbit == 4'd15) begin
                                ptr <= ptr + PTR_ONE;
                            end
                        end
                    end
                    WRITE: begin
                        spi_miso <= 1'b0;
                        if (rise) begin
                            shreg  <= {shreg[13:0], spi_mosi};
                            bitcnt <= bitcnt + 4'd1;
                            if (bitcnt == 4'd15) begin
                                mem[ptr] <= {shreg, spi_mosi};
                                ptr      <= ptr + PTR_ONE;
                            end
                        end
                    end
                    IGNORE: begin
                        spi_miso <= 1'b0;
                    end
                    default: begin
                        state    <= IDLE;
                        spi_miso <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
